// File: rtl/exc_entry_ctrl_pkg.sv
// Shared definitions for the exception entry/return sequencer:
// ExcCode values, CP0 register indices, SR/Cause field positions and
// the sequencer state encoding.
package exc_entry_ctrl_pkg;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NEXC = 5'd31;

  // CP0 register indices
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // SR fields
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;

  // Cause fields
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIR,
    ST_ERET_REDIR
  } state_t;

endpackage

// File: rtl/exc_entry_ctrl_if.sv
// MEM-stage exception summary, CP0 access port and pipeline control
// outputs of the exception sequencer. The pipeline side is the master.
interface exc_entry_ctrl_if;

  logic [4:0]  exc_code_m;
  logic [31:0] pc_epc_m;
  logic        delay_set_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        exl;
  logic        busy;

  modport master (
    output exc_code_m, pc_epc_m, delay_set_m, eret_m, hw_int,
           cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, exc_flush, pc_redirect, redirect_pc, exl, busy
  );

  modport slave (
    input  exc_code_m, pc_epc_m, delay_set_m, eret_m, hw_int,
           cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, exc_flush, pc_redirect, redirect_pc, exl, busy
  );

endinterface

// File: rtl/exc_entry_ctrl_cp0_regfile.sv
// CP0 SR/Cause/EPC/PRId storage with a combinational read mux.
// Exception entry has priority over eret, which has priority over mtc0.
// Cause and PRId are read-only to software; Cause.IP mirrors the live
// interrupt lines supplied by the parent.
module cp0_regfile
  import exc_entry_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_take,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_epc,
  input  logic        exc_bd,
  input  logic        eret_take,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [5:0]  ip,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [5:0]  sr_im,
  output logic        sr_exl,
  output logic        sr_ie,
  output logic [31:0] epc
);

  logic       cause_bd;
  logic [4:0] cause_code;

  // Register updates: exception entry, eret, or software write.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every CP0 register gets a reset value so SR starts with
    // interrupts disabled and EXL clear.
    if (!reset) begin
      sr_im      <= '0;
      sr_exl     <= 1'b0;
      sr_ie      <= 1'b0;
      cause_bd   <= 1'b0;
      cause_code <= '0;
      epc        <= '0;
    end else if (exc_take) begin
      // NOTE: non-blocking so all registers sample pre-edge values.
      epc        <= exc_epc;
      cause_bd   <= exc_bd;
      cause_code <= exc_code;
      sr_exl     <= 1'b1;
    end else if (eret_take) begin
      sr_exl <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        CP0_SR: begin
          sr_im  <= wr_data[SR_IM_HI:SR_IM_LO];
          sr_exl <= wr_data[SR_EXL];
          sr_ie  <= wr_data[SR_IE];
        end
        CP0_EPC: epc <= wr_data;
        default: ;
      endcase
    end
  end

  // Read mux; unimplemented bits and registers read as zero.
  always_comb begin
    // NOTE: default first so no path leaves rd_data unassigned (no latch).
    rd_data = '0;
    case (rd_addr)
      CP0_SR: begin
        rd_data[SR_IM_HI:SR_IM_LO] = sr_im;
        rd_data[SR_EXL]            = sr_exl;
        rd_data[SR_IE]             = sr_ie;
      end
      CP0_CAUSE: begin
        rd_data[CAUSE_BD]                    = cause_bd;
        rd_data[CAUSE_IP_HI:CAUSE_IP_LO]     = ip;
        rd_data[CAUSE_EXC_HI:CAUSE_EXC_LO]   = cause_code;
      end
      CP0_EPC:  rd_data = epc;
      CP0_PRID: rd_data = PRID_VAL;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: rtl/exc_entry_ctrl.sv
// Exception/interrupt entry and eret sequencer. Arbitrates interrupt >
// exception > eret > mtc0 in IDLE, then steps FLUSH -> REDIR (handler)
// or ERET_REDIR (flush + jump to EPC). Outputs are decoded from the state
// register. Optional macro EXC_IRQ_SYNC_EN adds a 2-flop synchronizer on
// hw_int ahead of interrupt qualification and Cause.IP.
module exc_entry_ctrl
  import exc_entry_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0000,
  parameter logic [4:0]  NEXC_CODE  = EXC_NEXC
) (
  input logic             clk,
  input logic             reset,
  exc_entry_ctrl_if.slave bus
);

  state_t      state, state_nxt;
  logic [5:0]  hw_int_eff;
  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic [31:0] epc;
  logic        int_req, exc_req;
  logic        exc_take, eret_take, wr_en;

`ifdef EXC_IRQ_SYNC_EN
  logic [5:0] hw_int_q1, hw_int_q2;

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hw_int_q1 <= '0;
      hw_int_q2 <= '0;
    end else begin
      hw_int_q1 <= bus.hw_int;
      hw_int_q2 <= hw_int_q1;
    end
  end

  assign hw_int_eff = hw_int_q2;
`else
  assign hw_int_eff = bus.hw_int;
`endif

  // Requests are masked while EXL is set; an interrupt needs a real
  // instruction (non-zero EPC candidate) to attach to.
  assign int_req = (|(hw_int_eff & sr_im)) & sr_ie & ~sr_exl &
                   (bus.pc_epc_m != '0);
  assign exc_req = (bus.exc_code_m != NEXC_CODE) & ~sr_exl;

  cp0_regfile #(.PRID_VAL(PRID_VAL)) u_cp0 (
    .clk       (clk),
    .reset     (reset),
    .exc_take  (exc_take),
    .exc_code  (int_req ? EXC_INT : bus.exc_code_m),
    .exc_epc   (bus.pc_epc_m),
    .exc_bd    (bus.delay_set_m),
    .eret_take (eret_take),
    .wr_en     (wr_en),
    .wr_addr   (bus.cp0_addr),
    .wr_data   (bus.cp0_wdata),
    .ip        (hw_int_eff),
    .rd_addr   (bus.cp0_addr),
    .rd_data   (bus.cp0_rdata),
    .sr_im     (sr_im),
    .sr_exl    (sr_exl),
    .sr_ie     (sr_ie),
    .epc       (epc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and CP0 update strobes; only IDLE accepts new work.
  always_comb begin
    state_nxt = state;
    exc_take  = 1'b0;
    eret_take = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (int_req || exc_req) begin
          exc_take  = 1'b1;
          state_nxt = ST_FLUSH;
        end else if (bus.eret_m) begin
          eret_take = 1'b1;
          state_nxt = ST_ERET_REDIR;
        end else if (bus.cp0_we) begin
          wr_en = 1'b1;
        end
      end
      ST_FLUSH:      state_nxt = ST_REDIR;
      ST_REDIR:      state_nxt = ST_IDLE;
      ST_ERET_REDIR: state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Pipeline control outputs decoded from the registered state.
  always_comb begin
    bus.exc_flush   = (state == ST_FLUSH) || (state == ST_ERET_REDIR);
    bus.pc_redirect = (state == ST_REDIR) || (state == ST_ERET_REDIR);
    bus.redirect_pc = '0;
    if (state == ST_REDIR)      bus.redirect_pc = HANDLER_PC;
    if (state == ST_ERET_REDIR) bus.redirect_pc = epc;
    bus.busy = (state != ST_IDLE);
    bus.exl  = sr_exl;
  end

endmodule

// File: tb/tb_exc_entry_ctrl.sv
// Self-checking bench for exc_entry_ctrl: a directed vector table, hand
// sequences for interrupt/priority/delay-slot/reset corners, and random
// stimulus against a queue-based behavioural model.
module tb_exc_entry_ctrl;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID    = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  exc_entry_ctrl_if bus ();

  exc_entry_ctrl #(.HANDLER_PC(HANDLER), .PRID_VAL(PRID), .NEXC_CODE(5'd31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        flush;
    logic        redir;
    logic [31:0] pc;
  } out_t;

  out_t        pend[$];  // outputs still to be shown, one per cycle
  logic [5:0]  m_im;
  logic        m_exl, m_ie, m_bd;
  logic [4:0]  m_code;
  logic [31:0] m_epc;
  logic [5:0]  m_q1, m_q2;

  task automatic model_reset();
    pend.delete();
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = 0; m_epc = 0;
    m_q1 = 0; m_q2 = 0;
  endtask

  function automatic logic [5:0] m_ip();
`ifdef EXC_IRQ_SYNC_EN
    return m_q2;
`else
    return bus.hw_int;
`endif
  endfunction

  function automatic logic [31:0] model_rdata(logic [4:0] a);
    case (a)
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ip()) << 10) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  // Effect of one rising edge with the inputs currently applied.
  task automatic model_step();
    logic [5:0] ip;
    bit ireq, ereq;
    ip = m_ip();
    if (pend.size() != 0) begin
      void'(pend.pop_front());
    end else begin
      ireq = ((ip & m_im) != 0) && m_ie && !m_exl && (bus.pc_epc_m != 0);
      ereq = (bus.exc_code_m != 5'd31) && !m_exl;
      if (ireq || ereq) begin
        m_epc  = bus.pc_epc_m;
        m_bd   = bus.delay_set_m;
        m_code = ireq ? 5'd0 : bus.exc_code_m;
        m_exl  = 1;
        pend.push_back('{1'b1, 1'b0, 32'h0});
        pend.push_back('{1'b0, 1'b1, HANDLER});
      end else if (bus.eret_m) begin
        m_exl = 0;
        pend.push_back('{1'b1, 1'b1, m_epc});
      end else if (bus.cp0_we) begin
        if (bus.cp0_addr == 5'd12) begin
          m_im  = bus.cp0_wdata[15:10];
          m_exl = bus.cp0_wdata[1];
          m_ie  = bus.cp0_wdata[0];
        end else if (bus.cp0_addr == 5'd14) begin
          m_epc = bus.cp0_wdata;
        end
      end
    end
    m_q2 = m_q1;
    m_q1 = bus.hw_int;
  endtask

  task automatic compare_outputs();
    out_t e;
    e = (pend.size() != 0) ? pend[0] : '{1'b0, 1'b0, 32'h0};
    check("exc_flush",   32'(bus.exc_flush),   32'(e.flush));
    check("pc_redirect", 32'(bus.pc_redirect), 32'(e.redir));
    check("redirect_pc", bus.redirect_pc,      e.pc);
    check("busy",        32'(bus.busy),        32'(pend.size() != 0));
    check("exl",         32'(bus.exl),         32'(m_exl));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    check("cp0_rdata", bus.cp0_rdata, model_rdata(bus.cp0_addr));
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_inputs();
    bus.exc_code_m = 5'd31; bus.pc_epc_m = 0; bus.delay_set_m = 0;
    bus.eret_m = 0; bus.hw_int = 0; bus.cp0_we = 0; bus.cp0_addr = 0;
    bus.cp0_wdata = 0;
  endtask

  task automatic read_check(string name, logic [4:0] a, logic [31:0] exp);
    bus.cp0_addr = a;
    #1;
    check(name, bus.cp0_rdata, exp);
  endtask

  task automatic leave_handler();
    idle_inputs();
    bus.eret_m = 1;
    cycle();
    idle_inputs();
    cycle();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        eret;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;     // read data before the edge
    logic        exp_flush;  // outputs after the edge
    logic        exp_redir;
    logic [31:0] exp_rpc;
    logic        exp_busy;
    logic        exp_exl;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{5'd31, 32'h0,    1'b0, 1'b0, 5'd12, 32'h0,   32'h0,      1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[1] = '{5'd31, 32'h0,    1'b0, 1'b1, 5'd12, 32'h401, 32'h0,      1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[2] = '{5'd31, 32'h0,    1'b0, 1'b0, 5'd12, 32'h0,   32'h401,    1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
    tbl[3] = '{5'd12, 32'h3010, 1'b0, 1'b0, 5'd14, 32'h0,   32'h0,      1'b1, 1'b0, 32'h0,    1'b1, 1'b1};
    tbl[4] = '{5'd31, 32'h0,    1'b0, 1'b0, 5'd13, 32'h0,   32'h30,     1'b0, 1'b1, HANDLER,  1'b1, 1'b1};
    tbl[5] = '{5'd31, 32'h0,    1'b0, 1'b0, 5'd14, 32'h0,   32'h3010,   1'b0, 1'b0, 32'h0,    1'b0, 1'b1};
    tbl[6] = '{5'd5,  32'h3040, 1'b0, 1'b0, 5'd12, 32'h0,   32'h403,    1'b0, 1'b0, 32'h0,    1'b0, 1'b1};
    tbl[7] = '{5'd31, 32'h0,    1'b1, 1'b0, 5'd14, 32'h0,   32'h3010,   1'b1, 1'b1, 32'h3010, 1'b1, 1'b0};
    tbl[8] = '{5'd31, 32'h0,    1'b0, 1'b0, 5'd12, 32'h0,   32'h401,    1'b0, 1'b0, 32'h0,    1'b0, 1'b0};

    idle_inputs();
    model_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_flush", 32'(bus.exc_flush), 32'h0);
    check("reset_redir", 32'(bus.pc_redirect), 32'h0);
    check("reset_rpc",   bus.redirect_pc, 32'h0);
    check("reset_busy",  32'(bus.busy), 32'h0);
    check("reset_exl",   32'(bus.exl), 32'h0);
    @(negedge clk);
    reset = 1;

    // Table: mtc0 SR, Ov exception entry, masked nested exception, eret.
    for (int i = 0; i < 9; i++) begin
      idle_inputs();
      bus.exc_code_m = tbl[i].code;
      bus.pc_epc_m   = tbl[i].pc;
      bus.eret_m     = tbl[i].eret;
      bus.cp0_we     = tbl[i].we;
      bus.cp0_addr   = tbl[i].addr;
      bus.cp0_wdata  = tbl[i].wdata;
      #1;
      check($sformatf("tbl%0d_rdata", i), bus.cp0_rdata, tbl[i].exp_rd);
      cycle();
      check($sformatf("tbl%0d_flush", i), 32'(bus.exc_flush),   32'(tbl[i].exp_flush));
      check($sformatf("tbl%0d_redir", i), 32'(bus.pc_redirect), 32'(tbl[i].exp_redir));
      check($sformatf("tbl%0d_rpc", i),   bus.redirect_pc,      tbl[i].exp_rpc);
      check($sformatf("tbl%0d_busy", i),  32'(bus.busy),        32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_exl", i),   32'(bus.exl),         32'(tbl[i].exp_exl));
    end

    // Interrupt on hw_int[0] with IM[10]/IE set.
    idle_inputs();
    bus.hw_int = 6'd1;
`ifdef EXC_IRQ_SYNC_EN
    repeat (2) cycle();
`endif
    bus.pc_epc_m = 32'h3020;
    cycle();
    check("int_flush", 32'(bus.exc_flush), 32'h1);
    idle_inputs();
    cycle();
    check("int_redir_pc", bus.redirect_pc, HANDLER);
    cycle();
    read_check("int_epc", 5'd14, 32'h3020);
    read_check("int_cause", 5'd13, 32'h0);
    leave_handler();

    // Interrupt and AdEL in the same cycle: interrupt wins.
    idle_inputs();
    bus.hw_int = 6'd1;
`ifdef EXC_IRQ_SYNC_EN
    repeat (2) cycle();
`endif
    bus.exc_code_m = 5'd4;
    bus.pc_epc_m   = 32'h3030;
    cycle();
    idle_inputs();
    repeat (2) cycle();
    read_check("prio_cause", 5'd13, 32'h0);
    read_check("prio_epc", 5'd14, 32'h3030);
    leave_handler();

    // Pending interrupt on a bubble (EPC candidate 0) is not taken.
    idle_inputs();
    bus.hw_int = 6'd1;
    repeat (3) cycle();
    check("bubble_no_busy", 32'(bus.busy), 32'h0);

    // Delay-slot RI with a coincident mtc0 EPC that must be dropped.
    idle_inputs();
    bus.exc_code_m = 5'd10; bus.pc_epc_m = 32'h3004; bus.delay_set_m = 1;
    bus.cp0_we = 1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'hdead_beef;
    cycle();
    idle_inputs();
    repeat (2) cycle();
    read_check("ds_cause", 5'd13, 32'h8000_0028);
    read_check("ds_epc", 5'd14, 32'h3004);
    leave_handler();

    // Cause and PRId are read-only.
    idle_inputs();
    bus.cp0_we = 1; bus.cp0_addr = 5'd13; bus.cp0_wdata = 32'hffff_ffff;
    cycle();
    bus.cp0_addr = 5'd15;
    cycle();
    idle_inputs();
    read_check("ro_cause", 5'd13, 32'h8000_0028);
    read_check("ro_prid", 5'd15, PRID);

    // Reset asserted during FLUSH clears outputs immediately.
    idle_inputs();
    bus.exc_code_m = 5'd12; bus.pc_epc_m = 32'h3050;
    cycle();
    check("rst_pre_flush", 32'(bus.exc_flush), 32'h1);
    idle_inputs();
    reset = 0;
    #1;
    check("rst_flush", 32'(bus.exc_flush), 32'h0);
    check("rst_redir", 32'(bus.pc_redirect), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_exl", 32'(bus.exl), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1;
    cycle();
    check("rst_idle_busy", 32'(bus.busy), 32'h0);
    read_check("rst_sr", 5'd12, 32'h0);

    // Random stimulus against the model.
    for (int n = 0; n < 800; n++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 25) begin
        case ($urandom_range(0, 5))
          0: bus.exc_code_m = 5'd0;
          1: bus.exc_code_m = 5'd4;
          2: bus.exc_code_m = 5'd5;
          3: bus.exc_code_m = 5'd10;
          4: bus.exc_code_m = 5'd12;
          default: bus.exc_code_m = 5'($urandom);
        endcase
      end
      bus.pc_epc_m    = ($urandom_range(0, 99) < 20) ? 32'h0 : ($urandom & 32'hffff_fffc);
      bus.delay_set_m = 1'($urandom);
      bus.eret_m      = ($urandom_range(0, 99) < 12);
      bus.hw_int      = ($urandom_range(0, 99) < 30) ? 6'($urandom) : 6'd0;
      bus.cp0_we      = ($urandom_range(0, 99) < 30);
      bus.cp0_addr    = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(12, 15)) : 5'($urandom);
      bus.cp0_wdata   = $urandom;
      if (bus.cp0_addr == 5'd12 && $urandom_range(0, 1) == 1)
        bus.cp0_wdata = bus.cp0_wdata & 32'hffff_fffd;  // mostly keep EXL clear
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
